// File: rtl/window_reg_array_if.sv
// Handshake and data bundle between the row source, the window register
// array and the PE row. The master side drives rows/config and accepts
// columns; the slave side is the window register array itself.
interface window_reg_array_if #(
  parameter int DW   = 32,
  parameter int BUFW = 48,
  parameter int POX  = 16,
  parameter int KW   = 3
);
  logic [KW-1:0]           cfg_ksize;
  logic [1:0]              cfg_stride;
  logic                    ld_valid;
  logic                    ld_ready;
  logic                    ld_src;
  logic [BUFW-1:0][DW-1:0] i_buf_data;
  logic [BUFW-1:0][DW-1:0] i_fifo_data;
  logic                    pe_valid;
  logic                    pe_ready;
  logic [POX-1:0][DW-1:0]  o_pe_data;
  logic [KW-1:0]           o_kx;
  logic                    o_last;
  logic                    o_row_done;
  logic                    o_cfg_err;

  modport master (
    output cfg_ksize, cfg_stride, ld_valid, ld_src, i_buf_data, i_fifo_data, pe_ready,
    input  ld_ready, pe_valid, o_pe_data, o_kx, o_last, o_row_done, o_cfg_err
  );

  modport slave (
    input  cfg_ksize, cfg_stride, ld_valid, ld_src, i_buf_data, i_fifo_data, pe_ready,
    output ld_ready, pe_valid, o_pe_data, o_kx, o_last, o_row_done, o_cfg_err
  );
endinterface

// File: rtl/window_reg_array.sv
// Sliding-window register array: loads one BUFW-word row, then presents
// ksize window columns to POX PEs, shifting the row by one word per
// accepted column. Stride 2 picks every other word for the PE lanes.
// Optional feature: define WINDOW_REG_ARRAY_PRELOAD_EN to add a shadow row
// bank so the next row can be loaded during emission (zero-bubble rows).
module window_reg_array #(
  parameter int DW   = 32,
  parameter int BUFW = 48,
  parameter int POX  = 16,
  parameter int KMAX = 7,
  parameter int KW   = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  window_reg_array_if.slave   bus
);

  localparam logic [0:0]    IDLE   = 1'b0;
  localparam logic [0:0]    EMIT   = 1'b1;
  localparam logic [KW-1:0] KMAX_K = KW'(KMAX);
  localparam logic [KW-1:0] K_ONE  = KW'(1);

  logic [0:0]              state;
  logic [BUFW-1:0][DW-1:0] mem;
  logic [BUFW-1:0][DW-1:0] load_row;
  logic [KW-1:0]           kx;
  logic [KW-1:0]           ksize;
  logic                    stride2;
  logic [KW-1:0]           san_ksize;
  logic                    san_stride2;
  logic                    cfg_bad;
  logic                    cfg_err;
  logic                    row_done;
  logic                    ld_ready;
  logic                    ld_fire;
  logic                    pe_valid;
  logic                    last_col;
  logic                    pe_fire;
  logic                    last_fire;
  logic [POX-1:0][DW-1:0]  pe_data;

`ifdef WINDOW_REG_ARRAY_PRELOAD_EN
  logic [BUFW-1:0][DW-1:0] shadow;
  logic                    shadow_full;
  logic [KW-1:0]           shadow_ksize;
  logic                    shadow_stride2;
`endif

  // Clamp the requested kernel size/stride into the legal range and flag illegal requests
  always_comb begin
    san_ksize = bus.cfg_ksize;
    if (bus.cfg_ksize == '0) begin
      san_ksize = K_ONE;
    end else if (bus.cfg_ksize > KMAX_K) begin
      san_ksize = KMAX_K;
    end
    san_stride2 = (bus.cfg_stride == 2'd2);
    cfg_bad     = (bus.cfg_ksize == '0) || (bus.cfg_ksize > KMAX_K) ||
                  (bus.cfg_stride == 2'd0) || (bus.cfg_stride == 2'd3);
    load_row    = bus.ld_src ? bus.i_fifo_data : bus.i_buf_data;
  end

  // Handshake qualifiers for both the load side and the PE side
  always_comb begin
    pe_valid  = (state == EMIT);
    last_col  = pe_valid && (kx == ksize - K_ONE);
    pe_fire   = pe_valid && bus.pe_ready;
    last_fire = pe_fire && last_col;
`ifdef WINDOW_REG_ARRAY_PRELOAD_EN
    ld_ready  = !shadow_full;
`else
    ld_ready  = (state == IDLE);
`endif
    ld_fire   = bus.ld_valid && ld_ready;
  end

  // PE lane i sees word i (stride 1) or word 2i (stride 2) of the current window
  for (genvar g = 0; g < POX; g++) begin : g_lane
    assign pe_data[g] = stride2 ? mem[2*g] : mem[g];
  end

  assign bus.ld_ready   = ld_ready;
  assign bus.pe_valid   = pe_valid;
  assign bus.o_pe_data  = pe_data;
  assign bus.o_kx       = kx;
  assign bus.o_last     = last_col;
  assign bus.o_row_done = row_done;
  assign bus.o_cfg_err  = cfg_err;

  // Row register, column counter, active config and state sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mem      <= '0;
      kx       <= '0;
      ksize    <= K_ONE;
      stride2  <= 1'b0;
      cfg_err  <= 1'b0;
      row_done <= 1'b0;
    end else begin
      row_done <= last_fire;
      if (ld_fire && cfg_bad) begin
        cfg_err <= 1'b1;
      end
      if (state == IDLE) begin
        if (ld_fire) begin
          mem     <= load_row;
          ksize   <= san_ksize;
          stride2 <= san_stride2;
          kx      <= '0;
          state   <= EMIT;
        end
      end else if (pe_fire) begin
        if (last_col) begin
          kx <= '0;
`ifdef WINDOW_REG_ARRAY_PRELOAD_EN
          if (shadow_full) begin
            mem     <= shadow;
            ksize   <= shadow_ksize;
            stride2 <= shadow_stride2;
          end else if (ld_fire) begin
            mem     <= load_row;
            ksize   <= san_ksize;
            stride2 <= san_stride2;
          end else begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end else begin
          mem <= {{DW{1'b0}}, mem[BUFW-1:1]};
          kx  <= kx + K_ONE;
        end
      end
    end
  end

`ifdef WINDOW_REG_ARRAY_PRELOAD_EN
  // Shadow bank captures a row arriving mid-emission and hands it over on the last column
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow         <= '0;
      shadow_full    <= 1'b0;
      shadow_ksize   <= K_ONE;
      shadow_stride2 <= 1'b0;
    end else begin
      if ((state == EMIT) && ld_fire && !last_fire) begin
        shadow         <= load_row;
        shadow_ksize   <= san_ksize;
        shadow_stride2 <= san_stride2;
        shadow_full    <= 1'b1;
      end else if (last_fire && shadow_full) begin
        shadow_full <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: doc/window_reg_array.md
Name: window_reg_array

Overview:
Parametrised sliding-window register array that sits between the input line buffer/FIFO and the PE row.
- Loads one BUFW-wide input row, then emits KSIZE window columns to POX PEs, one column per handshake.
- Runtime-configurable kernel size (1..KMAX) and stride (1 or 2).
- Valid/ready on both sides; row-done and config-error status.

Parameters:
DW, 32, data word width in bits
BUFW, 48, register array depth in words; must satisfy BUFW >= 2*(POX-1)+KMAX
POX, 16, number of PE outputs per column
KMAX, 7, maximum supported kernel size
KW, 3, width of ksize/column-index fields; must satisfy 2^KW > KMAX

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_ksize  in  KW  kernel size; sampled on load handshake
cfg_stride  in  2  stride, legal values 1 or 2; sampled on load handshake
ld_valid  in  1  row load request
ld_ready  out  1  array can accept a row
ld_src  in  1  0 = take i_buf_data, 1 = take i_fifo_data
i_buf_data  in  DW x BUFW  row from line buffer
i_fifo_data  in  DW x BUFW  row from reuse FIFO
pe_valid  out  1  o_pe_data holds a valid column
pe_ready  in  1  PEs accept column
o_pe_data  out  DW x POX  window column to PEs
o_kx  out  KW  column index within kernel, 0..ksize-1
o_last  out  1  current column is the last of the row
o_row_done  out  1  one-cycle pulse after the last column is accepted
o_cfg_err  out  1  sticky illegal-config flag

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; mem all zero; kx = 0.
  - pe_valid, o_last, o_row_done, o_cfg_err = 0.
  - ld_ready = 1 in the first cycle after reset release.
- FSM states: IDLE, EMIT.
- IDLE:
  - ld_ready = 1, pe_valid = 0.
  - On ld_valid&&ld_ready:
    - mem <= source selected by ld_src.
    - Latch ksize and stride.
    - kx <= 0; next state EMIT.
  - pe_valid is asserted the cycle after the load handshake (1-cycle latency).
- Config sanitising at latch:
  - ksize 0 is used as 1; ksize > KMAX is used as KMAX.
  - stride 0 or 3 is used as 1.
  - Any of these cases sets o_cfg_err, which stays set until reset.
- EMIT:
  - pe_valid = 1.
  - o_pe_data[i] = mem[i] when stride is 1; mem[2*i] when stride is 2. Purely combinational from mem.
  - o_kx = kx.
  - o_last = (kx == ksize-1).
- Handshake fire (pe_valid&&pe_ready):
  - Not last: for i = 0..BUFW-2, mem[i] <= mem[i+1]; mem[BUFW-1] <= 0; kx <= kx+1.
  - Last: kx <= 0; state <= IDLE; o_row_done pulses 1 for the next cycle.
- Stall (pe_valid && !pe_ready): mem, kx, o_pe_data and o_last are held stable.
- ksize = 1: a single column is emitted with o_last = 1 and no shift.
- ld_valid in EMIT is ignored (ld_ready = 0), except as described under the optional feature.
- Without the optional feature, back-to-back rows produce one bubble cycle: a row's last-column fire, then the next row's load cycle, then the next row's first column.
- rst_n asserted mid-row aborts immediately. The partially emitted row is discarded and no o_row_done is produced.

Optional Feature:
Macro: WINDOW_REG_ARRAY_PRELOAD_EN
- With the macro defined:
  - Adds a BUFW-word shadow bank and a shadow-full flag, plus shadow copies of ksize and stride.
  - ld_ready = !shadow_full in all states.
  - In EMIT, a load fills the shadow bank and latches the shadow config.
  - On last-column fire with shadow_full set:
    - mem <= shadow; config <= shadow config; shadow_full <= 0.
    - State stays EMIT with kx = 0, so the next row's first column appears on the next cycle (zero bubble).
    - o_row_done still pulses.
  - If last-column fire and a load coincide with the shadow empty, the load goes directly into mem, with the same zero-bubble result.
- With the macro undefined: no shadow logic; behaviour is exactly as in Behaviour.

Test Plan:
1. Reset then load from buf (ksize=3, stride=1, mem[j]=j), pe_ready=1 -> columns o_pe_data[0]=0,1,2 over 3 cycles; o_kx=0,1,2; o_last only on kx=2; o_row_done the next cycle.
2. stride=2, ksize=3, data mem[j]=j -> first column o_pe_data[i]=2i; second column o_pe_data[i]=2i+1; third o_pe_data[i]=2i+2.
3. Hold pe_ready=0 for 4 cycles at kx=1 -> o_pe_data, o_kx and o_last are stable; the column advances only after pe_ready=1.
4. cfg_ksize=0 and a separate load with cfg_stride=3 -> one column per row, stride 1; o_cfg_err=1 and remains 1 after further legal loads.
5. Assert rst_n low during kx=1 of a ksize=5 row -> outputs go to reset values asynchronously; no o_row_done; a fresh load works normally.
6. (PRELOAD_EN) Load row B during row A's emission -> row B kx=0 appears the cycle after row A's last fire, with no pe_valid gap; ld_ready drops while the shadow is full.
